// File: rtl/sdram_arb.sv
`default_nettype none
// sdram_arb: two-port arbiter in front of an SDRAM controller, one transaction outstanding.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module sdram_arb #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_rdy,
  input  logic                 mem_valid,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       owner;
  logic       seen_low;
  logic       rd_seen;
  logic       win;
  logic       issue;
  logic       wr_done;
  logic       rd_done;

`ifdef SDRAM_ARB_RR_EN
  logic last;

  always_comb begin
    win = (req0 && req1) ? ~last : req1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (issue) begin
      last <= win;
    end
  end
`else
  always_comb begin
    win = ~req0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      seen_low  <= 1'b0;
      rd_seen   <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= next_state;
      mem_en <= issue;
      gnt0   <= issue && !win;
      gnt1   <= issue && win;
      done0  <= (wr_done || rd_done) && !owner;
      done1  <= (wr_done || rd_done) && owner;
      if (issue) begin
        owner     <= win;
        mem_we    <= win ? we1 : we0;
        mem_addr  <= win ? addr1 : addr0;
        mem_wdata <= win ? wdata1 : wdata0;
        seen_low  <= 1'b0;
        rd_seen   <= 1'b0;
      end else begin
        if (state == BUSY && !mem_rdy) seen_low <= 1'b1;
        if (rd_done) rd_seen <= 1'b1;
      end
      if (rd_done) rdata <= mem_rdata;
    end
  end

  // ISSUE never looks at mem_rdy: the controller still shows idle while it latches mem_en.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_rdy && (req0 || req1)) next_state = ISSUE;
      ISSUE:   next_state = BUSY;
      BUSY:    if (seen_low && mem_rdy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    issue   = (state == IDLE) && mem_rdy && (req0 || req1);
    wr_done = (state == BUSY) && seen_low && mem_rdy && mem_we;
    rd_done = (state == BUSY) && !mem_we && mem_valid && !rd_seen;
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arb.sv
`default_nettype none
// tb_sdram_arb: directed self-checking bench; controller behaviour is driven by hand.
module tb_sdram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [12:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy, mem_valid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  sdram_arb #(.DATA_BITS(32), .ADDR_BITS(13)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] order;
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdy = 1'b1; mem_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ctrl", {60'd0, gnt0, gnt1, done0, done1}, 64'd0);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    rst = 1'b0;

    // write port 0, controller keeps stale ready one cycle after mem_en
    req0 = 1; we0 = 1; addr0 = 13'h0123; wdata0 = 32'hDEADBEEF;
    tick();
    chk("wr_gnt", {gnt0, gnt1, mem_en, mem_we}, 64'b1011);
    chk("wr_addr", {51'd0, mem_addr}, 64'h0123);
    chk("wr_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    req0 = 0;
    tick();
    chk("wr_issue_en", {gnt0, mem_en}, 64'd0);
    tick();
    chk("wr_stale_en", {mem_en, done0}, 64'd0);
    mem_rdy = 0;
    tick(); tick();
    chk("wr_busy_done", {done0, done1}, 64'd0);
    mem_rdy = 1;
    tick();
    chk("wr_done", {done0, done1, mem_en}, 64'b100);
    chk("wr_hold", {51'd0, mem_addr}, 64'h0123);
    tick();
    chk("wr_done_pulse", {done0, done1}, 64'd0);

    // read back
    req0 = 1; we0 = 0;
    tick();
    chk("rd_gnt", {gnt0, gnt1, mem_en, mem_we}, 64'b1010);
    req0 = 0;
    tick();
    mem_rdy = 0;
    tick(); tick();
    mem_valid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_done", {done0, done1}, 64'b10);
    chk("rd_data", {32'd0, rdata}, 64'hDEADBEEF);
    mem_valid = 0; mem_rdata = '0;
    tick();
    chk("rd_done_pulse", {done0, done1}, 64'd0);
    mem_rdy = 1;
    tick();
    chk("rd_no_second_done", {done0, done1}, 64'd0);
    chk("rd_data_hold", {32'd0, rdata}, 64'hDEADBEEF);

    // spurious valid in IDLE
    mem_valid = 1; mem_rdata = 32'h12345678;
    tick();
    chk("spur_done", {done0, done1}, 64'd0);
    chk("spur_rdata", {32'd0, rdata}, 64'hDEADBEEF);
    mem_valid = 0;

    // controller busy for 20 cycles while port 1 waits
    mem_rdy = 0; req1 = 1; we1 = 1; addr1 = 13'h1ABC; wdata1 = 32'hCAFEF00D;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("busy_no_issue", {mem_en, gnt1}, 64'd0);
    end
    mem_rdy = 1;
    tick();
    chk("busy_gnt1", {gnt0, gnt1, mem_en}, 64'b011);
    chk("busy_addr", {51'd0, mem_addr}, 64'h1ABC);
    req1 = 0;
    tick();
    mem_rdy = 0;
    tick();
    mem_rdy = 1;
    tick();
    chk("busy_done1", {done0, done1}, 64'b01);

    // tie: both ports keep requesting for four transactions
`ifdef SDRAM_ARB_RR_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 13'h0AAA; addr1 = 13'h0BBB;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_gnt", {gnt0, gnt1, mem_en}, {61'd0, !order[k], order[k], 1'b1});
      tick();
      chk("tie_issue", {gnt0, gnt1, mem_en}, 64'd0);
      mem_rdy = 0;
      tick();
      mem_rdy = 1;
      tick();
      chk("tie_done", {done0, done1}, {62'd0, !order[k], order[k]});
    end
    req0 = 0; req1 = 0;
    tick();

    // reset while busy on a read, with mem_valid in the same cycle
    req0 = 1; we0 = 0; addr0 = 13'h0555;
    tick();
    chk("mid_gnt", {gnt0, gnt1}, 64'b10);
    req0 = 0;
    tick();
    mem_rdy = 0;
    tick();
    rst = 1; mem_valid = 1; mem_rdata = 32'hAAAA5555;
    tick();
    chk("mid_rst_ctrl", {60'd0, gnt0, gnt1, done0, done1}, 64'd0);
    chk("mid_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    chk("mid_rst_rdata", {32'd0, rdata}, 64'd0);
    rst = 0; mem_valid = 0; mem_rdy = 1;
    req1 = 1; we1 = 0; addr1 = 13'h0777;
    tick();
    chk("mid_regrant", {gnt0, gnt1, mem_en, done0, done1}, 64'b01100);
    chk("mid_addr", {51'd0, mem_addr}, 64'h0777);
    req1 = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter: DATA_BITS, default 32, width of the write and read data paths.
REQ-002 Parameter: ADDR_BITS, default 13, width of the {bank, address} word passed to the SDRAM controller.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0/req1  in  1  request from port 0/1; held high with its fields until the matching gnt.
REQ-006 we0/we1  in  1  1 = write, 0 = read.
REQ-007 addr0/addr1  in  ADDR_BITS  request address {Ba, Addr}.
REQ-008 wdata0/wdata1  in  DATA_BITS  write data.
REQ-009 gnt0/gnt1  out  1  one-cycle pulse; the port's request fields are captured this cycle.
REQ-010 done0/done1  out  1  one-cycle completion pulse to the owning port.
REQ-011 rdata  out  DATA_BITS  read data; meaningful only while done is high for a read.
REQ-012 mem_en  out  1  controller request strobe.
REQ-013 mem_we  out  1  controller write select.
REQ-014 mem_addr  out  ADDR_BITS  controller address.
REQ-015 mem_wdata  out  DATA_BITS  controller write data.
REQ-016 mem_rdy  in  1  controller idle indication; high every cycle the controller is idle.
REQ-017 mem_valid  in  1  controller read-data strobe.
REQ-018 mem_rdata  in  DATA_BITS  controller read data.

Function
REQ-019 All outputs shall be registered; the state machine shall have three states: IDLE, ISSUE, BUSY.
REQ-020 In IDLE, when mem_rdy=1 and any req is high, the block shall select a winner and register winner fields onto mem_we/mem_addr/mem_wdata.
- Same cycle: mem_en=1 and gnt<winner>=1 for exactly one cycle.
- Next state: ISSUE.
REQ-021 In IDLE with mem_rdy=0 or no requests, mem_en shall stay 0 and no gnt shall assert.
REQ-022 ISSUE shall last exactly one cycle with mem_en=0, masking the stale mem_rdy=1 the controller still presents; next state BUSY.
REQ-023 In BUSY the block shall wait for mem_rdy=0, then for mem_rdy=1, and then return to IDLE.
REQ-024 Read completion: on the mem_valid cycle, rdata<=mem_rdata and done<owner>=1 for one cycle.
REQ-025 Write completion: done<owner>=1 on the cycle the BUSY state observes the mem_rdy 0->1 return.
REQ-026 The earliest re-arbitration shall be the cycle after return to IDLE; at most one transaction shall be outstanding.
REQ-027 mem_valid outside BUSY, or during a write, shall be ignored: no done, rdata unchanged.
REQ-028 mem_addr, mem_we and mem_wdata shall hold their values from issue until the next grant.
REQ-029 A req that drops before its gnt shall be withdrawn with no side effects.

Reset
REQ-030 On rst the following shall be 0: gnt0/1, done0/1, mem_en, mem_we, mem_addr, mem_wdata, rdata.
REQ-031 On rst the state shall be IDLE and the last-grant pointer shall be 1, so port 0 wins the first tie.
REQ-032 A reset asserted in ISSUE or BUSY shall abandon the transaction without a done pulse; the controller is reset alongside.

Configuration
REQ-033 Macro SDRAM_ARB_RR_EN defined: round-robin arbitration.
- On simultaneous requests, the port not granted last wins.
- The last-grant pointer updates on every gnt.
REQ-034 Macro SDRAM_ARB_RR_EN undefined: fixed priority.
- Port 0 always wins ties.
- The pointer logic is absent.

Verification
REQ-035 Write then read: after reset, mem_rdy=1; req0 write addr=13'h0123, wdata=32'hDEADBEEF.
- Expect: gnt0 and mem_en on the same cycle; mem_addr=13'h0123, mem_we=1.
- Expect: done0 one cycle after mem_rdy returns high.
- Then req0 read addr=13'h0123; model returns 32'hDEADBEEF on mem_valid -> done0 with rdata=32'hDEADBEEF.
REQ-036 Tie with SDRAM_ARB_RR_EN: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1.
- Without the macro -> 0,0,0,0 while req0 stays high.
REQ-037 Busy controller: mem_rdy held 0 for 20 cycles while req1 is high -> no mem_en and no gnt1.
- Then gnt1 on the first cycle mem_rdy=1.
REQ-038 Stale ready: controller model keeps mem_rdy=1 for one cycle after mem_en -> exactly one mem_en pulse, no double issue.
REQ-039 Reset mid-operation: rst asserted in BUSY during a read, with mem_valid arriving in the same cycle -> no done0/done1, all outputs 0, state IDLE.
- Then req1 is granted normally.
REQ-040 Spurious valid: mem_valid pulsed while in IDLE -> no done, rdata unchanged.
